// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - I/O region address map shared by Control and io_controller
package io_map_pkg;

  // Addr[31:28] value that selects the I/O region
  localparam logic [3:0] IO_NIBBLE  = 4'h8;

  // Addr[11:8] value that selects the counter page instead of a UART channel
  localparam logic [3:0] CNT_PAGE   = 4'hF;

  // UART channel register offsets (Addr[7:0])
  localparam logic [7:0] OFF_TXCTRL = 8'h00;
  localparam logic [7:0] OFF_RXCTRL = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_RXDATA = 8'h0C;

  // Counter page register offsets (Addr[7:0])
  localparam logic [7:0] OFF_CYC    = 8'h00;
  localparam logic [7:0] OFF_INS    = 8'h04;
  localparam logic [7:0] OFF_CNTRST = 8'h08;

endpackage

// File: rtl/io_uart_port.sv
// rtl/io_uart_port.sv - one UART channel: tx byte latch, tx/rx pulses, sticky error bits
module io_uart_port (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_wr,
  input  logic       txctrl_rd,
  input  logic       rxctrl_rd,
  input  logic       rxdata_rd,
  input  logic [7:0] wdata,
  input  logic       tx_ready,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       rx_ready,
  output logic       tx_drop,
  output logic       rx_under
);

  // Pulses last exactly one cycle per access; sticky bits set on error and clear on
  // a ctrl read, with set taking priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      rx_ready <= 1'b0;
      tx_drop  <= 1'b0;
      rx_under <= 1'b0;
    end else begin
      tx_valid <= tx_wr && tx_ready;
      rx_ready <= rxdata_rd && rx_valid;
      if (tx_wr && tx_ready) begin
        tx_data <= wdata;
      end
      if (tx_wr && !tx_ready) begin
        tx_drop <= 1'b1;
      end else if (txctrl_rd) begin
        tx_drop <= 1'b0;
      end
      if (rxdata_rd && !rx_valid) begin
        rx_under <= 1'b1;
      end else if (rxctrl_rd) begin
        rx_under <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_controller.sv
// rtl/io_controller.sv - memory-mapped UART channels and cycle/instruction counters
module io_controller #(
  parameter int         NUM_UART  = 2,
  parameter logic [3:0] IO_NIBBLE = io_map_pkg::IO_NIBBLE,
  parameter int         CNT_W     = 32
) (
  input  logic                  Clock,
  input  logic                  reset_n,
  input  logic [31:0]           Addr,
  input  logic [31:0]           WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  Stall,
  input  logic                  InstrRetire,
  output logic [31:0]           ReadData,
  output logic [8*NUM_UART-1:0] UARTTxData,
  output logic [NUM_UART-1:0]   UARTTxValid,
  input  logic [NUM_UART-1:0]   UARTTxReady,
  input  logic [8*NUM_UART-1:0] UARTRxData,
  input  logic [NUM_UART-1:0]   UARTRxValid,
  output logic [NUM_UART-1:0]   UARTRxReady
);

  import io_map_pkg::*;

  logic             io;
  logic             rd_en;
  logic             wr_en;
  logic [3:0]       page;
  logic [7:0]       off;
  logic             cnt_sel;
  logic             cnt_rst;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ins_cnt;
  logic [31:0]      rdata_next;
  logic [NUM_UART-1:0] tx_drop;
  logic [NUM_UART-1:0] rx_under;

  // A simultaneous load and store behaves as a store: no read side effects, ReadData 0
  assign io      = (Addr[31:28] == IO_NIBBLE) && !Stall;
  assign rd_en   = io && MemRead && !MemWrite;
  assign wr_en   = io && MemWrite;
  assign page    = Addr[11:8];
  assign off     = {Addr[7:2], 2'b00};
  assign cnt_sel = (page == CNT_PAGE);
  assign cnt_rst = wr_en && cnt_sel && (off == OFF_CNTRST);

  // Address bits that play no part in decode and store bits UARTs never see
  logic unused_bits;
  assign unused_bits = &{1'b0, Addr[27:12], Addr[1:0], WriteData[31:8]};

  genvar c;
  generate
    for (c = 0; c < NUM_UART; c++) begin : g_port
      localparam logic [3:0] CH = 4'(c);
      logic ch_sel;
      assign ch_sel = (page == CH);

      io_uart_port u_port (
        .clk       (Clock),
        .rst_n     (reset_n),
        .tx_wr     (wr_en && ch_sel && (off == OFF_TXDATA)),
        .txctrl_rd (rd_en && ch_sel && (off == OFF_TXCTRL)),
        .rxctrl_rd (rd_en && ch_sel && (off == OFF_RXCTRL)),
        .rxdata_rd (rd_en && ch_sel && (off == OFF_RXDATA)),
        .wdata     (WriteData[7:0]),
        .tx_ready  (UARTTxReady[c]),
        .rx_valid  (UARTRxValid[c]),
        .tx_data   (UARTTxData[8*c +: 8]),
        .tx_valid  (UARTTxValid[c]),
        .rx_ready  (UARTRxReady[c]),
        .tx_drop   (tx_drop[c]),
        .rx_under  (rx_under[c])
      );
    end
  endgenerate

  // Counters free-run (stall does not stop them); a counter-reset store wins over increment
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else if (cnt_rst) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (InstrRetire) begin
        ins_cnt <= ins_cnt + CNT_W'(1);
      end
    end
  end

  // Read mux; anything unmapped, write-only or beyond NUM_UART returns 0
  always_comb begin
    rdata_next = '0;
    if (cnt_sel) begin
      case (off)
        OFF_CYC: rdata_next = 32'(cyc_cnt);
        OFF_INS: rdata_next = 32'(ins_cnt);
        default: rdata_next = '0;
      endcase
    end else begin
      for (int i = 0; i < NUM_UART; i++) begin
        if (page == 4'(i)) begin
          case (off)
            OFF_TXCTRL: rdata_next = {30'b0, tx_drop[i], UARTTxReady[i]};
            OFF_RXCTRL: rdata_next = {30'b0, rx_under[i], UARTRxValid[i]};
            OFF_RXDATA: rdata_next = UARTRxValid[i] ? {24'b0, UARTRxData[8*i +: 8]} : 32'b0;
            default:    rdata_next = '0;
          endcase
        end
      end
    end
  end

  // Registered load data, one-cycle latency like block-RAM; non-load edges load 0
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      ReadData <= '0;
    end else begin
      ReadData <= rd_en ? rdata_next : 32'b0;
    end
  end

endmodule

// File: tb/tb_io_controller.sv
// tb/tb_io_controller.sv - directed vector bench for io_controller
module tb_io_controller;

  localparam int NU = 2;
  localparam int CW = 8;

  logic          Clock;
  logic          reset_n;
  logic [31:0]   Addr;
  logic [31:0]   WriteData;
  logic          MemRead;
  logic          MemWrite;
  logic          Stall;
  logic          InstrRetire;
  logic [31:0]   ReadData;
  logic [8*NU-1:0] UARTTxData;
  logic [NU-1:0] UARTTxValid;
  logic [NU-1:0] UARTTxReady;
  logic [8*NU-1:0] UARTRxData;
  logic [NU-1:0] UARTRxValid;
  logic [NU-1:0] UARTRxReady;

  int n_checks = 0;
  int n_fail   = 0;

  io_controller #(.NUM_UART(NU), .IO_NIBBLE(4'h8), .CNT_W(CW)) dut (
    .Clock       (Clock),
    .reset_n     (reset_n),
    .Addr        (Addr),
    .WriteData   (WriteData),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Stall       (Stall),
    .InstrRetire (InstrRetire),
    .ReadData    (ReadData),
    .UARTTxData  (UARTTxData),
    .UARTTxValid (UARTTxValid),
    .UARTTxReady (UARTTxReady),
    .UARTRxData  (UARTRxData),
    .UARTRxValid (UARTRxValid),
    .UARTRxReady (UARTRxReady)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic        stall;
    logic [1:0]  txr;
    logic [1:0]  rxv;
    logic [15:0] rxd;
    logic [31:0] e_rd;
    logic [1:0]  e_txv;
    logic [1:0]  e_rxr;
    logic [15:0] e_txd;
  } vec_t;

  vec_t tbl [0:25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr, input logic ret);
    Addr = a; WriteData = wd; MemRead = rd; MemWrite = wr; InstrRetire = ret;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Addr = 32'h0; WriteData = 32'h0; MemRead = 1'b0; MemWrite = 1'b0; Stall = 1'b0;
    InstrRetire = 1'b0; UARTTxReady = '0; UARTRxValid = '0; UARTRxData = '0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;

    tbl[0]  = '{32'h80000108, 32'hA5, 0, 1, 0, 2'b10, 2'b00, 16'h0000, 32'h0,  2'b10, 2'b00, 16'hA500};
    tbl[1]  = '{32'h80000000, 32'h0,  0, 0, 0, 2'b00, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA500};
    tbl[2]  = '{32'h80000108, 32'h5A, 0, 1, 0, 2'b00, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA500};
    tbl[3]  = '{32'h80000100, 32'h0,  1, 0, 0, 2'b00, 2'b00, 16'h0000, 32'h2,  2'b00, 2'b00, 16'hA500};
    tbl[4]  = '{32'h80000100, 32'h0,  1, 0, 0, 2'b00, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA500};
    tbl[5]  = '{32'h8000000C, 32'h0,  1, 0, 0, 2'b00, 2'b01, 16'h003C, 32'h3C, 2'b00, 2'b01, 16'hA500};
    tbl[6]  = '{32'h8000000C, 32'h0,  1, 0, 0, 2'b00, 2'b00, 16'h003C, 32'h0,  2'b00, 2'b00, 16'hA500};
    tbl[7]  = '{32'h80000004, 32'h0,  1, 0, 0, 2'b00, 2'b00, 16'h0000, 32'h2,  2'b00, 2'b00, 16'hA500};
    tbl[8]  = '{32'h80000004, 32'h0,  1, 0, 0, 2'b00, 2'b01, 16'h0000, 32'h1,  2'b00, 2'b00, 16'hA500};
    tbl[9]  = '{32'h80000008, 32'h11, 0, 1, 1, 2'b11, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA500};
    tbl[10] = '{32'h10000000, 32'h0,  1, 0, 0, 2'b00, 2'b11, 16'hFFFF, 32'h0,  2'b00, 2'b00, 16'hA500};
    tbl[11] = '{32'h8000050C, 32'h0,  1, 0, 0, 2'b00, 2'b11, 16'hFFFF, 32'h0,  2'b00, 2'b00, 16'hA500};
    tbl[12] = '{32'h80000008, 32'h0,  1, 0, 0, 2'b11, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA500};
    tbl[13] = '{32'h80000008, 32'h77, 1, 1, 0, 2'b01, 2'b00, 16'h0000, 32'h0,  2'b01, 2'b00, 16'hA577};
    tbl[14] = '{32'h8ABCD10F, 32'h0,  1, 0, 0, 2'b00, 2'b10, 16'hC300, 32'hC3, 2'b00, 2'b10, 16'hA577};
    tbl[15] = '{32'h80000008, 32'h01, 0, 1, 0, 2'b01, 2'b00, 16'h0000, 32'h0,  2'b01, 2'b00, 16'hA501};
    tbl[16] = '{32'h80000008, 32'h02, 0, 1, 0, 2'b00, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA501};
    tbl[17] = '{32'h80000000, 32'h0,  1, 0, 0, 2'b01, 2'b00, 16'h0000, 32'h3,  2'b00, 2'b00, 16'hA501};
    tbl[18] = '{32'h80000008, 32'h03, 0, 1, 1, 2'b00, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA501};
    tbl[19] = '{32'h80000000, 32'h0,  1, 0, 0, 2'b00, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA501};
    tbl[20] = '{32'h8000000C, 32'h0,  1, 0, 1, 2'b00, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA501};
    tbl[21] = '{32'h80000004, 32'h0,  1, 0, 0, 2'b00, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA501};
    tbl[22] = '{32'h80000010, 32'h0,  1, 0, 0, 2'b00, 2'b01, 16'h0055, 32'h0,  2'b00, 2'b00, 16'hA501};
    tbl[23] = '{32'h80000F0C, 32'h0,  1, 0, 0, 2'b00, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA501};
    tbl[24] = '{32'h80000F08, 32'h0,  1, 0, 0, 2'b00, 2'b00, 16'h0000, 32'h0,  2'b00, 2'b00, 16'hA501};
    tbl[25] = '{32'h8000000C, 32'h99, 0, 1, 0, 2'b00, 2'b01, 16'h0066, 32'h0,  2'b00, 2'b00, 16'hA501};

    // reset state
    repeat (2) @(posedge Clock);
    #1;
    check("reset ReadData", ReadData, 32'h0);
    check("reset TxValid", 32'(UARTTxValid), 32'h0);
    check("reset RxReady", 32'(UARTRxReady), 32'h0);
    check("reset TxData", 32'(UARTTxData), 32'h0);

    // let the counters run, then reset in the middle of a tx pulse
    reset_n = 1'b1;
    repeat (5) bus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    UARTTxReady = 2'b10;
    bus(32'h80000108, 32'h0000005C, 1'b0, 1'b1, 1'b0);
    check("pre-reset pulse", 32'(UARTTxValid), 32'h2);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check("async reset TxValid", 32'(UARTTxValid), 32'h0);
    check("async reset TxData", 32'(UARTTxData), 32'h0);
    @(posedge Clock);
    #1;
    reset_n = 1'b1;
    bus(32'h80000F00, 32'h0, 1'b1, 1'b0, 1'b0);
    check("post-reset no pulse", 32'(UARTTxValid), 32'h0);
    check("post-reset cyc", ReadData, 32'h0);
    bus(32'h80000F04, 32'h0, 1'b1, 1'b0, 1'b0);
    check("post-reset ins", ReadData, 32'h0);

    // vector table
    for (int i = 0; i < 26; i++) begin
      Stall = tbl[i].stall;
      UARTTxReady = tbl[i].txr;
      UARTRxValid = tbl[i].rxv;
      UARTRxData = tbl[i].rxd;
      bus(tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].wr, 1'b0);
      check($sformatf("v%0d ReadData", i), ReadData, tbl[i].e_rd);
      check($sformatf("v%0d TxValid", i), 32'(UARTTxValid), 32'(tbl[i].e_txv));
      check($sformatf("v%0d RxReady", i), 32'(UARTRxReady), 32'(tbl[i].e_rxr));
      check($sformatf("v%0d TxData", i), 32'(UARTTxData), 32'(tbl[i].e_txd));
    end
    idle_inputs();

    // counters: 10 cycles with retire on alternate cycles
    bus(32'h80000F08, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      bus(32'h0, 32'h0, 1'b0, 1'b0, (i % 2) == 1);
    end
    bus(32'h80000F00, 32'h0, 1'b1, 1'b0, 1'b0);
    check("cyc after 10", ReadData, 32'd10);
    bus(32'h80000F04, 32'h0, 1'b1, 1'b0, 1'b0);
    check("ins after 10", ReadData, 32'd5);

    // counter reset overrides a same-cycle retire
    bus(32'h80000F08, 32'h0, 1'b0, 1'b1, 1'b1);
    bus(32'h80000F00, 32'h0, 1'b1, 1'b0, 1'b0);
    check("cyc after clr", ReadData, 32'h0);
    bus(32'h80000F04, 32'h0, 1'b1, 1'b0, 1'b0);
    check("ins after clr", ReadData, 32'h0);

    // stalled counter reset is suppressed
    Stall = 1'b1;
    bus(32'h80000F08, 32'h0, 1'b0, 1'b1, 1'b0);
    Stall = 1'b0;
    bus(32'h80000F00, 32'h0, 1'b1, 1'b0, 1'b0);
    check("stalled clr ignored", ReadData, 32'd3);

    // wrap from all-ones
    bus(32'h80000F08, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) begin
      bus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    end
    bus(32'h80000F04, 32'h0, 1'b1, 1'b0, 1'b1);
    check("ins all-ones", ReadData, 32'h000000FF);
    bus(32'h80000F00, 32'h0, 1'b1, 1'b0, 1'b0);
    check("cyc wrapped", ReadData, 32'h0);
    bus(32'h80000F04, 32'h0, 1'b1, 1'b0, 1'b0);
    check("ins wrapped", ReadData, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
